// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment scan driver.
//   - Active-low glyph patterns, seg[0]=a ... seg[6]=g.
//   - Scan FSM state type.
package seg_pkg;

    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_A   = 7'h08;
    localparam logic [6:0] SEG_B   = 7'h03;
    localparam logic [6:0] SEG_C   = 7'h46;
    localparam logic [6:0] SEG_D   = 7'h21;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_F   = 7'h0E;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } seg_state_t;

endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: combinational hex nibble to active-low seven-segment glyph.
// Ports:
//   i_nib  [3:0]  hex value
//   o_seg  [6:0]  active-low segments, bit 0 = a ... bit 6 = g
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        case (i_nib)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_segment_mux.sv
// seven_segment_mux: round-robin scan driver for NUM_DIGITS common-anode
// digits on one shared active-low segment bus. Each digit slot is BLANK for
// BLANK_CYCLES clocks, then ON for DWELL_CYCLES clocks. Inputs are captured
// into a shadow register once per frame so a frame never mixes two values.
//
// Optional feature: define SEG_MUX_LZ_BLANK_EN to blank leading zeros
// (digits k>0 whose nibble and all more-significant nibbles are zero).
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high
//   digits_i     hex nibbles, nibble k = digits_i[4k+3:4k], digit 0 = LSD
//   dp_i         decimal point request per digit, active-high
//   seg          active-low segments (registered)
//   dp_n         active-low decimal point (registered)
//   an_n         active-low anode enables, at most one low (registered)
//   frame_start  one-cycle pulse; shadow loads on the edge ending it
module seven_segment_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 2,
    parameter int DWELL_CYCLES = 24000,
    parameter int BLANK_CYCLES = 480
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_start
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // Counter runs load..0, so each phase lasts exactly load+1 clocks.
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    seg_state_t                r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [IDX_W-1:0]          r_idx;
    logic [4*NUM_DIGITS-1:0]   r_shadow;
    logic [NUM_DIGITS-1:0]     r_shadow_dp;
    logic [6:0]                r_seg;
    logic                      r_dp_n;
    logic [NUM_DIGITS-1:0]     r_an_n;
    logic                      r_frame_start;

    seg_state_t                w_state_nxt;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic [IDX_W-1:0]          w_idx_nxt;
    logic                      w_fs_nxt;
    logic [4*NUM_DIGITS-1:0]   w_sh_nxt;
    logic [NUM_DIGITS-1:0]     w_shdp_nxt;
    logic [NUM_DIGITS-1:0]     w_lz;
    logic [3:0]                w_nib;
    logic                      w_dp_sel;
    logic                      w_lz_sel;
    logic [NUM_DIGITS-1:0]     w_an_sel;
    logic [6:0]                w_glyph;
    logic [6:0]                w_seg_nxt;
    logic                      w_dp_n_nxt;
    logic [NUM_DIGITS-1:0]     w_an_n_nxt;

    // Output registers are loaded from the shadow value that will exist after
    // this edge; with BLANK_CYCLES=1 the capture edge is also the BLANK->ON
    // edge, and digit 0 must show the freshly captured value.
    assign w_sh_nxt   = r_frame_start ? digits_i : r_shadow;
    assign w_shdp_nxt = r_frame_start ? dp_i     : r_shadow_dp;

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt - 1'b1;
        w_idx_nxt   = r_idx;
        w_fs_nxt    = 1'b0;
        if (r_cnt == '0) begin
            if (r_state == BLANK) begin
                w_state_nxt = ON;
                w_cnt_nxt   = DWELL_LOAD;
            end else begin
                w_state_nxt = BLANK;
                w_cnt_nxt   = BLANK_LOAD;
                w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
                // Entering BLANK of digit 0 starts a new frame.
                w_fs_nxt    = (w_idx_nxt == '0);
            end
        end
    end

`ifdef SEG_MUX_LZ_BLANK_EN
    // w_lz[k]: nibble k and every nibble above it are zero. Digit 0 never blanks.
    always_comb begin
        logic zero_run;
        w_lz     = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_run = zero_run && (w_sh_nxt[4*k +: 4] == 4'h0);
            w_lz[k]  = zero_run;
        end
    end
`else
    assign w_lz = '0;
`endif

    // Select the digit that will be active after this edge.
    always_comb begin
        w_nib    = 4'h0;
        w_dp_sel = 1'b0;
        w_lz_sel = 1'b0;
        w_an_sel = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_idx_nxt == IDX_W'(k)) begin
                w_nib       = w_sh_nxt[4*k +: 4];
                w_dp_sel    = w_shdp_nxt[k];
                w_lz_sel    = w_lz[k];
                w_an_sel[k] = 1'b1;
            end
        end
    end

    hex_to_seg u_hex_to_seg (
        .i_nib (w_nib),
        .o_seg (w_glyph)
    );

    always_comb begin
        w_an_n_nxt = '1;
        w_seg_nxt  = SEG_OFF;
        w_dp_n_nxt = 1'b1;
        if (w_state_nxt == ON) begin
            w_an_n_nxt = ~w_an_sel;
            w_seg_nxt  = w_lz_sel ? SEG_OFF : w_glyph;
            w_dp_n_nxt = ~w_dp_sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= BLANK;
            r_cnt         <= BLANK_LOAD;
            r_idx         <= '0;
            r_shadow      <= '0;
            r_shadow_dp   <= '0;
            r_seg         <= SEG_OFF;
            r_dp_n        <= 1'b1;
            r_an_n        <= '1;
            r_frame_start <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_idx         <= w_idx_nxt;
            r_shadow      <= w_sh_nxt;
            r_shadow_dp   <= w_shdp_nxt;
            r_seg         <= w_seg_nxt;
            r_dp_n        <= w_dp_n_nxt;
            r_an_n        <= w_an_n_nxt;
            r_frame_start <= w_fs_nxt;
        end
    end

    assign seg         = r_seg;
    assign dp_n        = r_dp_n;
    assign an_n        = r_an_n;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Bench for seven_segment_mux: two instances (2 digits B=2 D=4, and
// 3 digits B=1 D=3) checked every cycle against a timeline model that derives
// the expected outputs from the cycle count since reset release.
module tb_seven_segment_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  digits0;
    logic [1:0]  dp0;
    logic [11:0] digits1;
    logic [2:0]  dp1;
    logic [6:0]  seg0, seg1;
    logic        dp_n0, dp_n1;
    logic [1:0]  an_n0;
    logic [2:0]  an_n1;
    logic        fs0, fs1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seven_segment_mux #(.NUM_DIGITS(2), .DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut0 (
        .clk(clk), .reset(reset), .digits_i(digits0), .dp_i(dp0),
        .seg(seg0), .dp_n(dp_n0), .an_n(an_n0), .frame_start(fs0)
    );

    seven_segment_mux #(.NUM_DIGITS(3), .DWELL_CYCLES(3), .BLANK_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .digits_i(digits1), .dp_i(dp1),
        .seg(seg1), .dp_n(dp_n1), .an_n(an_n1), .frame_start(fs1)
    );

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Expected outputs in cycle t after reset release, from the scan timeline.
    function automatic void model(input int n, input int b, input int d, input int t,
                                  input logic [31:0] sh, input logic [7:0] shdp,
                                  output logic [6:0] s, output logic [7:0] an,
                                  output logic dpn, output logic fs);
        int p, slot, ph;
        logic [3:0] nib;
        p    = b + d;
        slot = (t / p) % n;
        ph   = t % p;
        fs   = ((t % (n * p)) == 0);
        an   = 8'hFF;
        s    = 7'h7F;
        dpn  = 1'b1;
        if (ph >= b) begin
            an[slot] = 1'b0;
            nib      = 4'((sh >> (4 * slot)) & 32'hF);
            s        = GLYPH[nib];
            dpn      = ~shdp[slot];
`ifdef SEG_MUX_LZ_BLANK_EN
            if (slot > 0 && (sh >> (4 * slot)) == 32'h0) s = 7'h7F;
`endif
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model state: cycle count and captured shadow per instance.
    int         m_t0, m_t1;
    logic [7:0]  m_sh0;
    logic [1:0]  m_dp0;
    logic [11:0] m_sh1;
    logic [2:0]  m_dp1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_t0 <= 0; m_t1 <= 0;
            m_sh0 <= '0; m_dp0 <= '0; m_sh1 <= '0; m_dp1 <= '0;
        end else begin
            if (m_t0 % 12 == 0) begin m_sh0 <= digits0; m_dp0 <= dp0; end
            if (m_t1 % 12 == 0) begin m_sh1 <= digits1; m_dp1 <= dp1; end
            m_t0 <= m_t0 + 1;
            m_t1 <= m_t1 + 1;
        end
    end

    logic [6:0] es0, es1;
    logic [7:0] ea0, ea1;
    logic       ed0, ed1, ef0, ef1;

    always @(negedge clk) begin
        model(2, 2, 4, m_t0, {24'h0, m_sh0}, {6'h0, m_dp0}, es0, ea0, ed0, ef0);
        model(3, 1, 3, m_t1, {20'h0, m_sh1}, {5'h0, m_dp1}, es1, ea1, ed1, ef1);
        check("dut0_outputs", {21'h0, an_n0, seg0, dp_n0, fs0}, {21'h0, ea0[1:0], es0, ed0, ef0});
        check("dut1_outputs", {20'h0, an_n1, seg1, dp_n1, fs1}, {20'h0, ea1[2:0], es1, ed1, ef1});
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset   = 1'b1;
        digits0 = 8'h3A;
        dp0     = 2'b10;
        digits1 = 12'h3A5;
        dp1     = 3'b000;
        cyc(2);
        check("reset_dut0", {an_n0, seg0, dp_n0, fs0}, {2'b11, 7'h7F, 1'b1, 1'b1});
        check("reset_dut1", {an_n1, seg1, dp_n1, fs1}, {3'b111, 7'h7F, 1'b1, 1'b1});

        // Release; this cycle is t=0.
        reset = 1'b0;
        #1;
        check("t0_fs_dut0", {an_n0, fs0}, {2'b11, 1'b1});
        cyc(1);                                                   // t=1
        check("t1_dut1_d0", {an_n1, seg1, dp_n1}, {3'b110, 7'h12, 1'b1});
        cyc(1);                                                   // t=2
        check("t2_dut0_d0", {an_n0, seg0, dp_n0, fs0}, {2'b10, 7'h08, 1'b1, 1'b0});
        cyc(3);                                                   // t=5
        check("t5_dut1_d1", {an_n1, seg1}, {3'b101, 7'h08});
        cyc(3);                                                   // t=8
        check("t8_dut0_d1", {an_n0, seg0, dp_n0, fs0}, {2'b01, 7'h30, 1'b0, 1'b0});
        cyc(1);                                                   // t=9
        check("t9_dut1_d2", {an_n1, seg1}, {3'b011, 7'h30});
        cyc(3);                                                   // t=12
        check("t12_fs_dut0", {an_n0, seg0, fs0}, {2'b11, 7'h7F, 1'b1});
        check("t12_fs_dut1", fs1, 1'b1);
        cyc(1);                                                   // t=13
        check("t13_dut1_wrap", an_n1, 3'b110);

        // Tear-free: change mid digit-0 ON phase of frame 1.
        cyc(2);                                                   // t=15
        digits0 = 8'h5C;
        cyc(5);                                                   // t=20
        check("tear_d1_old", {an_n0, seg0, dp_n0}, {2'b01, 7'h30, 1'b0});
        cyc(6);                                                   // t=26
        check("new_d0_C", {an_n0, seg0, dp_n0}, {2'b10, 7'h46, 1'b1});
        cyc(6);                                                   // t=32
        check("new_d1_5", {an_n0, seg0, dp_n0}, {2'b01, 7'h12, 1'b0});

        // Reset during ON: outputs dark before any clock edge.
        cyc(1);                                                   // t=33
        #2 reset = 1'b1;
        #1;
        check("async_rst_dut0", {an_n0, seg0, dp_n0}, {2'b11, 7'h7F, 1'b1});
        check("async_rst_dut1", {an_n1, seg1, dp_n1}, {3'b111, 7'h7F, 1'b1});
        cyc(2);
        reset = 1'b0;
        #1;
        check("rerelease_fs", {fs0, fs1}, 2'b11);
        cyc(2);                                                   // t=2
        check("restart_d0", an_n0, 2'b10);

        // Glyph sweep on dut0, one value per frame; dut1 gets new inputs every cycle.
        for (int v = 0; v < 256; v++) begin
            digits0 = 8'(v);
            dp0     = 2'($urandom);
            for (int c = 0; c < 12; c++) begin
                cyc(1);
                digits1 = 12'($urandom);
                dp1     = 3'($urandom);
            end
        end

        // Inputs changing at arbitrary phases on both instances.
        for (int c = 0; c < 300; c++) begin
            cyc(1);
            if ($urandom_range(0, 3) == 0) digits0 = 8'($urandom);
            if ($urandom_range(0, 3) == 0) dp0     = 2'($urandom);
            digits1 = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 15)) : 12'($urandom);
            dp1     = 3'($urandom);
        end

        cyc(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
